// File: rtl/cmult_rr_sched_pkg.sv
// Shared types and helpers for the round-robin complex-multiplier scheduler.
package cmult_rr_sched_pkg;

  typedef enum logic [0:0] {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } sched_state_e;

  function automatic int unsigned prod_width(input int unsigned w1, input int unsigned w2);
    return w1 + w2 + 32'd1;
  endfunction

endpackage

// File: rtl/cmult_rr_sched_cmult.sv
// Pipelined full-precision complex multiplier; deliberately has no reset, like the
// hard multiplier it models, so stale data can sit in it across a scheduler reset.
module cmult_rr_sched_cmult #(
  parameter int DIN1_WIDTH = 16,
  parameter int DIN2_WIDTH = 16,
  parameter int MULT_LAT   = 6,
  localparam int PW = DIN1_WIDTH + DIN2_WIDTH,
  localparam int W  = PW + 1
) (
  input  logic                         clk,
  input  logic signed [DIN1_WIDTH-1:0] a_re,
  input  logic signed [DIN1_WIDTH-1:0] a_im,
  input  logic signed [DIN2_WIDTH-1:0] b_re,
  input  logic signed [DIN2_WIDTH-1:0] b_im,
  input  logic                         din_valid,
  output logic signed [W-1:0]          dout_re,
  output logic signed [W-1:0]          dout_im,
  output logic                         dout_valid
);

  logic signed [PW-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;
  logic signed [W-1:0]  re_dly_r [MULT_LAT-1];
  logic signed [W-1:0]  im_dly_r [MULT_LAT-1];
  logic [MULT_LAT-1:0]  v_pipe_r;

  // Partial products, sum stage, then delay padding up to MULT_LAT
  always_ff @(posedge clk) begin
    p_rr_r <= PW'(a_re) * PW'(b_re);
    p_ii_r <= PW'(a_im) * PW'(b_im);
    p_ri_r <= PW'(a_re) * PW'(b_im);
    p_ir_r <= PW'(a_im) * PW'(b_re);
    re_dly_r[0] <= W'(p_rr_r) - W'(p_ii_r);
    im_dly_r[0] <= W'(p_ri_r) + W'(p_ir_r);
    for (int i = 1; i < MULT_LAT - 1; i++) begin
      re_dly_r[i] <= re_dly_r[i-1];
      im_dly_r[i] <= im_dly_r[i-1];
    end
    v_pipe_r <= {v_pipe_r[MULT_LAT-2:0], din_valid};
  end

  assign dout_re    = re_dly_r[MULT_LAT-2];
  assign dout_im    = im_dly_r[MULT_LAT-2];
  assign dout_valid = v_pipe_r[MULT_LAT-1];

endmodule

// File: rtl/cmult_rr_sched.sv
// Round-robin scheduler sharing one complex multiplier among NREQ requesters,
// with a tag pipe carrying requester id/user bit alongside each product.
module cmult_rr_sched
  import cmult_rr_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DIN1_WIDTH = 16,
  parameter int DIN2_WIDTH = 16,
  parameter int MULT_LAT   = 6,
  localparam int IDW = $clog2(NREQ),
  localparam int W   = int'(prod_width(DIN1_WIDTH, DIN2_WIDTH))
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_user,
  input  logic [NREQ*DIN1_WIDTH-1:0]   din1_re,
  input  logic [NREQ*DIN1_WIDTH-1:0]   din1_im,
  input  logic [NREQ*DIN2_WIDTH-1:0]   din2_re,
  input  logic [NREQ*DIN2_WIDTH-1:0]   din2_im,
  output logic signed [W-1:0]          dout_re,
  output logic signed [W-1:0]          dout_im,
  output logic [IDW-1:0]               dout_id,
  output logic                         dout_user,
  output logic                         dout_valid,
  output logic                         err_align
);

  localparam int CW = $clog2(MULT_LAT + 1);

  sched_state_e                 state_r;
  logic [CW-1:0]                flush_cnt_r;
  logic [IDW-1:0]               ptr_r;
  logic [IDW-1:0]               gnt_idx_s;
  logic                         gnt_found_s;
  logic                         hit_s;
  int                           cand_s;
  logic [NREQ-1:0]              ready_s;
  logic                         transfer_s;
  logic [IDW-1:0]               next_ptr_s;

  logic signed [DIN1_WIDTH-1:0] op1_re_r, op1_im_r;
  logic signed [DIN2_WIDTH-1:0] op2_re_r, op2_im_r;
  logic                         din_v_r;
  logic signed [W-1:0]          mult_re_s, mult_im_s;
  logic                         mult_valid_s;

  logic [MULT_LAT:0]            tag_v_r;
  logic [MULT_LAT:0]            tag_u_r;
  logic [IDW-1:0]               tag_id_r [MULT_LAT+1];

  // Priority search starting at the pointer, wrapping NREQ-1 -> 0
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    hit_s       = 1'b0;
    cand_s      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s      = int'(ptr_r) + i;
      cand_s      = (cand_s >= NREQ) ? cand_s - NREQ : cand_s;
      hit_s       = !gnt_found_s && req_valid[cand_s[IDW-1:0]];
      gnt_idx_s   = hit_s ? cand_s[IDW-1:0] : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_s;
    end
  end

  // Grant only in Run and never while reset is being applied
  always_comb begin
    if ((state_r == ST_RUN) && rst && gnt_found_s) begin
      ready_s = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
    end else begin
      ready_s = '0;
    end
    transfer_s = |(ready_s & req_valid);
    next_ptr_s = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1'b1);
  end

  assign req_ready = ready_s;

  // Flush/Run control and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_FLUSH;
      flush_cnt_r <= CW'(MULT_LAT);
      ptr_r       <= '0;
    end else begin
      case (state_r)
        ST_FLUSH: begin
          if (flush_cnt_r == CW'(1'b1)) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= '0;
          end else begin
            flush_cnt_r <= flush_cnt_r - CW'(1'b1);
          end
        end
        ST_RUN: begin
          if (transfer_s) begin
            ptr_r <= next_ptr_s;
          end
        end
        default: begin
          state_r     <= ST_FLUSH;
          flush_cnt_r <= CW'(MULT_LAT);
        end
      endcase
    end
  end

  // Registered operand mux feeding the shared multiplier
  always_ff @(posedge clk) begin
    if (!rst) begin
      din_v_r  <= 1'b0;
      op1_re_r <= '0;
      op1_im_r <= '0;
      op2_re_r <= '0;
      op2_im_r <= '0;
    end else begin
      din_v_r <= transfer_s;
      if (transfer_s) begin
        op1_re_r <= din1_re[gnt_idx_s*DIN1_WIDTH +: DIN1_WIDTH];
        op1_im_r <= din1_im[gnt_idx_s*DIN1_WIDTH +: DIN1_WIDTH];
        op2_re_r <= din2_re[gnt_idx_s*DIN2_WIDTH +: DIN2_WIDTH];
        op2_im_r <= din2_im[gnt_idx_s*DIN2_WIDTH +: DIN2_WIDTH];
      end
    end
  end

  cmult_rr_sched_cmult #(
    .DIN1_WIDTH (DIN1_WIDTH),
    .DIN2_WIDTH (DIN2_WIDTH),
    .MULT_LAT   (MULT_LAT)
  ) u_mult (
    .clk        (clk),
    .a_re       (op1_re_r),
    .a_im       (op1_im_r),
    .b_re       (op2_re_r),
    .b_im       (op2_im_r),
    .din_valid  (din_v_r),
    .dout_re    (mult_re_s),
    .dout_im    (mult_im_s),
    .dout_valid (mult_valid_s)
  );

  // Tag pipe: stage 0 lines up with the operand register, last stage with mult dout_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_v_r <= '0;
      tag_u_r <= '0;
      for (int i = 0; i <= MULT_LAT; i++) begin
        tag_id_r[i] <= '0;
      end
    end else begin
      tag_v_r     <= {tag_v_r[MULT_LAT-1:0], transfer_s};
      tag_u_r     <= {tag_u_r[MULT_LAT-1:0], req_user[gnt_idx_s]};
      tag_id_r[0] <= gnt_idx_s;
      for (int i = 1; i <= MULT_LAT; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  // Output register; the tag pipe, not the unreset multiplier, decides validity
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_valid <= 1'b0;
      dout_id    <= '0;
      dout_user  <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      err_align  <= 1'b0;
    end else begin
      dout_valid <= (state_r == ST_RUN) && tag_v_r[MULT_LAT];
      if ((state_r == ST_RUN) && tag_v_r[MULT_LAT]) begin
        dout_id   <= tag_id_r[MULT_LAT];
        dout_user <= tag_u_r[MULT_LAT];
        dout_re   <= mult_re_s;
        dout_im   <= mult_im_s;
      end
      if ((state_r == ST_RUN) && (tag_v_r[MULT_LAT] != mult_valid_s)) begin
        err_align <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmult_rr_sched.sv
// Directed, table-driven bench for cmult_rr_sched with a latency-exact product scoreboard.
module tb_cmult_rr_sched;

  localparam int NREQ = 4;
  localparam int L    = 6;
  localparam int W    = 33;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready, req_user;
  logic [NREQ*16-1:0] din1_re, din1_im, din2_re, din2_im;
  logic signed [W-1:0] dout_re, dout_im;
  logic [1:0]        dout_id;
  logic              dout_user, dout_valid, err_align;

  logic signed [15:0] a_re [NREQ];
  logic signed [15:0] a_im [NREQ];
  logic signed [15:0] b_re [NREQ];
  logic signed [15:0] b_im [NREQ];

  typedef struct {
    logic [3:0]          rv;
    logic [3:0]          ru;
    logic [3:0]          er;
    logic [1:0]          eid;
    logic                eu;
    logic signed [W-1:0] ere;
    logic signed [W-1:0] eim;
  } vec_t;

  typedef struct {
    int                  due;
    logic [1:0]          id;
    logic                user;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } exp_t;

  vec_t tbl [64];
  int   n_vec = 0;
  exp_t sb [$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  cmult_rr_sched #(.NREQ(NREQ), .DIN1_WIDTH(16), .DIN2_WIDTH(16), .MULT_LAT(L)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_user(req_user),
    .din1_re(din1_re), .din1_im(din1_im), .din2_re(din2_re), .din2_im(din2_im),
    .dout_re(dout_re), .dout_im(dout_im), .dout_id(dout_id), .dout_user(dout_user),
    .dout_valid(dout_valid), .err_align(err_align)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      din1_re[k*16 +: 16] = a_re[k];
      din1_im[k*16 +: 16] = a_im[k];
      din2_re[k*16 +: 16] = b_re[k];
      din2_im[k*16 +: 16] = b_im[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each expected product must appear on exactly its due cycle
  always @(negedge clk) begin
    if (mon_en) begin
      automatic logic exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      chk("dout_valid", 64'(dout_valid), 64'(exp_v));
      if (exp_v) begin
        automatic exp_t e = sb.pop_front();
        chk("dout_id",   64'(dout_id),   64'(e.id));
        chk("dout_user", 64'(dout_user), 64'(e.user));
        chk("dout_re",   64'(dout_re),   64'(e.re));
        chk("dout_im",   64'(dout_im),   64'(e.im));
      end
    end
  end

  task automatic add(input logic [3:0] rv, input logic [3:0] ru, input logic [3:0] er,
                     input logic [1:0] eid, input logic eu,
                     input logic signed [W-1:0] ere, input logic signed [W-1:0] eim);
    tbl[n_vec] = '{rv, ru, er, eid, eu, ere, eim};
    n_vec++;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      req_valid = tbl[i].rv;
      req_user  = tbl[i].ru;
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(tbl[i].er));
      if (tbl[i].er != 4'd0) begin
        sb.push_back('{cyc + L + 2, tbl[i].eid, tbl[i].eu, tbl[i].ere, tbl[i].eim});
      end
      @(posedge clk);
      #1;
    end
    req_valid = 4'd0;
    req_user  = 4'd0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic set_ops(input int k, input int ar, input int ai, input int br, input int bi);
    a_re[k] = 16'(ar); a_im[k] = 16'(ai); b_re[k] = 16'(br); b_im[k] = 16'(bi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int phase_a;
    rst = 1'b0;
    req_valid = 4'hF;
    req_user = 4'd0;
    set_ops(0, 1, 2, 3, 4);
    set_ops(1, 3, 4, 1, -2);
    set_ops(2, 2, -1, 2, 1);
    set_ops(3, -5, 7, 3, -2);

    // Vector table: products hand-computed per requester operand set
    for (int k = 0; k < 8; k++) begin
      case (k % 4)
        0: add(4'hF, 4'h0, 4'b0001, 2'd0, 1'b0, -5, 10);
        1: add(4'hF, 4'h0, 4'b0010, 2'd1, 1'b0, 11, -2);
        2: add(4'hF, 4'h0, 4'b0100, 2'd2, 1'b0, 5, 0);
        default: add(4'hF, 4'h0, 4'b1000, 2'd3, 1'b0, -1, 31);
      endcase
    end
    add(4'b0010, 4'h0, 4'b0010, 2'd1, 1'b0, 11, -2);
    phase_a = n_vec;
    add(4'b0010, 4'h0, 4'b0010, 2'd1, 1'b0, 33'sd1073741824, 0);
    for (int k = 0; k < 10; k++) begin
      add(4'b0100, (k == 9) ? 4'b0100 : 4'b0000, 4'b0100, 2'd2, (k == 9), 5, 0);
    end
    add(4'b0101, 4'h0, 4'b0001, 2'd0, 1'b0, -5, 10);
    add(4'b0101, 4'h0, 4'b0100, 2'd2, 1'b0, 5, 0);
    add(4'b0101, 4'h0, 4'b0001, 2'd0, 1'b0, -5, 10);
    add(4'b0000, 4'h0, 4'b0000, 2'd0, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",      64'(req_ready),  64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout_id",    64'(dout_id),    64'd0);
    chk("rst_dout_user",  64'(dout_user),  64'd0);
    chk("rst_err_align",  64'(err_align),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk("flush_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end

    run_range(0, phase_a);
    set_ops(1, -32768, 0, -32768, 0);
    run_range(phase_a, n_vec);
    drain();

    // Reset in the middle of traffic: in-flight products vanish, held request survives
    set_ops(1, 3, 4, 1, -2);
    mon_en = 1'b0;
    req_valid = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk("flush2_ready", 64'(req_ready), 64'd0);
      chk("flush2_dout_valid", 64'(dout_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("first_run_grant", 64'(req_ready), 64'b0010);
    sb.push_back('{cyc + L + 2, 2'd1, 1'b0, 33'sd11, -33'sd2});
    @(posedge clk);
    #1;
    req_valid = 4'd0;
    mon_en = 1'b1;
    drain();

    // Misalignment: a spurious multiplier valid latches err_align until reset
    @(negedge clk);
    chk("err_before", 64'(err_align), 64'd0);
    @(posedge clk);
    #1;
    force u_dut.mult_valid_s = 1'b1;
    @(posedge clk);
    #1;
    release u_dut.mult_valid_s;
    @(negedge clk);
    chk("err_set", 64'(err_align), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 64'(err_align), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("err_cleared", 64'(err_align), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
